regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the 4x8 datapath register file.
- Provides NUM_REGS x DATA_W storage with two combinational read ports and one synchronous write port clocked on the rising edge of clk (no derived write strobe).
- Adds write-to-read bypass, a per-register pending scoreboard for multicycle producers, and a stall output for the control unit.
- Sits between decode (reads, reservations) and writeback (writes) of the microprocessor core.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 2, register address width.
- NUM_REGS, 1<<ADDR_W, number of registers; must be <= 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  system clock, rising edge active.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_data2  out  DATA_W  read port 2 data, combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- rsv_en  in  1  reserve a destination (mark pending).
- rsv_addr  in  ADDR_W  destination being reserved.
- busy1  out  1  rd_addr1 target pending.
- busy2  out  1  rd_addr2 target pending.
- stall  out  1  busy1 | busy2.
- wr_ack  out  1  registered one-cycle pulse, 1 clk after an accepted write.
- rsv_err  out  1  sticky: reservation issued to an already-pending register.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers = 0, pending = 0, wr_ack = 0, rsv_err = 0.
  - Reset mid-operation discards in-flight writes and reservations.
  - First write is possible on the first rising edge after reset_n deasserts.
- Write:
  - At posedge clk with wr_en=1 and wr_addr < NUM_REGS: reg[wr_addr] <= wr_data.
  - Out-of-range addresses are ignored; no wr_ack for them.
- wr_ack: registered copy of an accepted write, high exactly one cycle.
- Read:
  - rd_dataN = reg[rd_addrN].
  - If BYPASS=1 and wr_en and wr_addr == rd_addrN (in range): rd_dataN = wr_data (zero-latency forward).
  - Out-of-range read returns 0.
- Scoreboard:
  - pending[i] set at posedge when rsv_en and rsv_addr == i.
  - pending[i] cleared at posedge when an accepted write targets i.
  - Simultaneous rsv and write to the same register: reservation wins; pending stays 1 and data is still written.
  - Reservation to a register already pending and not being written that cycle: rsv_err <= 1. rsv_err is sticky until reset.
- busyN:
  - busyN = pending[rd_addrN], except busyN = 0 when BYPASS=1 and the same-cycle write targets rd_addrN.
  - busyN = pending[rd_addrN] when BYPASS=0 (no early release).
- stall is purely combinational from busy1 and busy2.
- Both read ports may address the same register; their results are identical.

Optional Feature:
- Macro: REGFILE_SB_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0; writes to 0 are dropped, with no wr_ack.
  - Reservations of 0 are ignored; busy is never asserted for address 0.
  - Bypass never forwards to address 0.
- Undefined: register 0 is a normal register.

Decomposition:
- Package regfile_pkg:
  - Default DATA_W/ADDR_W constants.
  - reg_addr_t and reg_data_t typedefs.
  - Constant ZERO_REG = 0.
- Sub-module regfile_scoreboard: pending vector, busy/stall logic and rsv_err.
- Storage, bypass and wr_ack stay in the top module.

Test Plan:
- Reset: write 8'hA5 to r1, pulse reset_n low mid-cycle -> rd_data1 = 0 immediately, wr_ack = 0, pending = 0.
- Write/read: wr r2 = 8'h3C at edge k -> wr_ack high in cycle k+1 only; rd_addr1=2 returns 8'h3C from k+1.
- Bypass: BYPASS=1, wr_en with r3 = 8'h7E, rd_addr2=3 in the same cycle -> rd_data2 = 8'h7E before the edge. BYPASS=0 -> old value returned.
- Scoreboard: rsv r1 -> busy1 = stall = 1 while rd_addr1=1; write r1 = 8'h11 -> busy1 drops the same cycle (BYPASS=1) and pending clears after the edge.
- Collision: rsv r2 and wr r2 in the same cycle -> r2 updated and pending[2] stays 1. Second rsv r2 -> rsv_err = 1, held until reset.
- REGFILE_SB_ZERO_REG_EN: wr r0 = 8'hFF and rsv r0 -> rd_data1(r0) = 0, busy1 = 0, no wr_ack.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, types and zero-register switch for regfile_sb
// REGFILE_SB_ZERO_REG_EN defined: register 0 is hardwired to zero
package regfile_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int ZERO_REG = 0;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
`ifdef REGFILE_SB_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, busy/stall and sticky reservation error
// REGFILE_SB_ZERO_REG_EN defined: reservations of register 0 are ignored
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic              rsv_err
);
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  logic [NUM_REGS-1:0] pending, pending_nxt;
  logic rsv_ok, err_set;
  assign rsv_ok = rsv_en && ({1'b0, rsv_addr} < NR) && !(ZERO_EN && rsv_addr == ADDR_W'(ZERO_REG));
  // a write landing in the same cycle retires the old reservation, so no error
  assign err_set = rsv_ok && pending[rsv_addr] && !(wr_ok && wr_addr == rsv_addr);
  always_comb begin
    pending_nxt = pending;
    if (wr_ok) pending_nxt[wr_addr] = 1'b0;
    if (rsv_ok) pending_nxt[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      rsv_err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      rsv_err <= rsv_err | err_set;
    end
  always_comb begin
    busy1 = ({1'b0, rd_addr1} < NR) ? pending[rd_addr1] : 1'b0;
    busy2 = ({1'b0, rd_addr2} < NR) ? pending[rd_addr2] : 1'b0;
    if (BYPASS != 0 && wr_ok && wr_addr == rd_addr1) busy1 = 1'b0;
    if (BYPASS != 0 && wr_ok && wr_addr == rd_addr2) busy2 = 1'b0;
  end
  assign stall = busy1 | busy2;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NUM_REGS x DATA_W register file, 2 read / 1 write, bypass, scoreboard, stall
// REGFILE_SB_ZERO_REG_EN defined: register 0 reads 0, ignores writes and reservations
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic              wr_ack,
  output logic              rsv_err
);
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_addr} < NR) && !(ZERO_EN && wr_addr == ADDR_W'(ZERO_REG));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      if (wr_ok) regs[wr_addr] <= wr_data;
    end
  // register 0 is never written when hardwired, so it keeps its reset zero
  always_comb begin
    rd_data1 = (BYPASS != 0 && wr_ok && wr_addr == rd_addr1) ? wr_data :
               (({1'b0, rd_addr1} < NR) ? regs[rd_addr1] : '0);
    rd_data2 = (BYPASS != 0 && wr_ok && wr_addr == rd_addr2) ? wr_data :
               (({1'b0, rd_addr2} < NR) ? regs[rd_addr2] : '0);
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_ok    (wr_ok),
    .wr_addr  (wr_addr),
    .busy1    (busy1),
    .busy2    (busy2),
    .stall    (stall),
    .rsv_err  (rsv_err)
  );
endmodule
